// File: rtl/load_store_group_decoder.sv
`default_nettype none
// ============================================================================
// Module   : load_store_group_decoder
// Brief    : Control decoder for LD/ST/LDB/STB with seven addressing modes.
//            Define LDS_BYTE_OPS_EN to enable byte loads/stores.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_group_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] opf,
    input  logic [2:0] modef,
    input  logic       fetch,
    input  logic       decode,
    input  logic       execute,
    input  logic       commit,
    output logic       rega_en,
    output logic       regb_en,
    output logic       rega_wen,
    output logic       regb_wen,
    output logic [3:0] alu_opx,
    output logic [2:0] alua_srcx,
    output logic [2:0] alub_srcx,
    output logic [1:0] rega_dinx,
    output logic [1:0] rega_addrx,
    output logic [2:0] regb_addrx,
    output logic [1:0] rega_byte_enx,
    output logic [1:0] regb_byte_enx,
    output logic [1:0] data_busx,
    output logic [1:0] addr_busx,
    output logic       rdx,
    output logic       wrx,
    output logic       bytex,
    output logic [1:0] pc_offsetx
);

    localparam logic [3:0] c_ALU_ADD        = 4'd0;
    localparam logic [2:0] c_ALUA_ZERO      = 3'd0;
    localparam logic [2:0] c_ALUA_U5_0      = 3'd1;
    localparam logic [2:0] c_ALUA_TWO       = 3'd2;
    localparam logic [2:0] c_ALUA_MINUS_TWO = 3'd3;
    localparam logic [2:0] c_ALUB_REG_B     = 3'd0;
    localparam logic [1:0] c_DIN_DATA_BUS   = 2'd0;
    localparam logic [1:0] c_RA_ARGA        = 2'd0;
    localparam logic [2:0] c_RB_ARGB        = 3'd0;
    localparam logic [2:0] c_RB_RFP         = 3'd1;
    localparam logic [2:0] c_RB_RSP         = 3'd2;
    localparam logic [2:0] c_RB_RRS         = 3'd3;
    localparam logic [1:0] c_BE_WORD        = 2'b11;
    localparam logic [1:0] c_BE_LOW         = 2'b01;
    localparam logic [1:0] c_DB_MEM         = 2'd0;
    localparam logic [1:0] c_DB_REGA_DOUT   = 2'd1;
    localparam logic [1:0] c_AB_PC          = 2'd0;
    localparam logic [1:0] c_AB_ALUB_DATA   = 2'd1;
    localparam logic [1:0] c_AB_ALU_R       = 2'd2;
    localparam logic [1:0] c_AB_HERE        = 2'd3;
    localparam logic [1:0] c_PCO_NONE       = 2'd0;
    localparam logic [1:0] c_PCO_SKIP_WORD  = 2'd1;
    localparam logic [2:0] c_MODE_RESERVED  = 3'd7;

    logic [1:0] r_opf;
    logic [2:0] r_modef;
    logic       w_active;
    logic       w_load;
    logic       w_byte_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opf   <= 2'b00;
            r_modef <= 3'b000;
        end else if (decode) begin
            r_opf   <= opf;
            r_modef <= modef;
        end
    end

    // Reset is folded in directly so outputs drop to defaults the instant it asserts.
    assign w_active = rst_n && (execute || commit) && !fetch && !decode
                      && (r_modef != c_MODE_RESERVED);
    assign w_load   = !r_opf[0];

`ifdef LDS_BYTE_OPS_EN
    assign w_byte_op = r_opf[1];
`else
    logic w_unused_opf;
    assign w_unused_opf = r_opf[1];
    assign w_byte_op    = 1'b0;
`endif

    always_comb begin
        rega_en       = 1'b0;
        regb_en       = 1'b0;
        rega_wen      = 1'b0;
        regb_wen      = 1'b0;
        alu_opx       = c_ALU_ADD;
        alua_srcx     = c_ALUA_ZERO;
        alub_srcx     = c_ALUB_REG_B;
        rega_dinx     = c_DIN_DATA_BUS;
        rega_addrx    = c_RA_ARGA;
        regb_addrx    = c_RB_ARGB;
        rega_byte_enx = c_BE_WORD;
        regb_byte_enx = c_BE_WORD;
        data_busx     = c_DB_MEM;
        addr_busx     = c_AB_PC;
        rdx           = 1'b0;
        wrx           = 1'b0;
        bytex         = 1'b0;
        pc_offsetx    = c_PCO_NONE;

        if (w_active) begin
            rega_en = 1'b1;
            regb_en = 1'b1;

            case (r_modef)
                3'd0: begin alua_srcx = c_ALUA_ZERO;      addr_busx = c_AB_ALUB_DATA; end
                3'd1: begin alua_srcx = c_ALUA_TWO;       addr_busx = c_AB_ALUB_DATA; end
                3'd2: begin alua_srcx = c_ALUA_MINUS_TWO; addr_busx = c_AB_ALU_R;     end
                3'd3: begin alua_srcx = c_ALUA_ZERO;      addr_busx = c_AB_HERE;      end
                3'd4: begin alua_srcx = c_ALUA_U5_0; addr_busx = c_AB_ALU_R; regb_addrx = c_RB_RFP; end
                3'd5: begin alua_srcx = c_ALUA_U5_0; addr_busx = c_AB_ALU_R; regb_addrx = c_RB_RSP; end
                3'd6: begin alua_srcx = c_ALUA_U5_0; addr_busx = c_AB_ALU_R; regb_addrx = c_RB_RRS; end
                default: ;
            endcase

            if (w_load) begin
                rdx      = 1'b1;
                rega_wen = commit;
            end else begin
                data_busx = c_DB_REGA_DOUT;
                wrx       = commit;
            end

            // Auto-increment/decrement modes write the ALU result back to Rb.
            regb_wen = commit && ((r_modef == 3'd1) || (r_modef == 3'd2));
            if (commit && (r_modef == 3'd3))
                pc_offsetx = c_PCO_SKIP_WORD;

            if (w_byte_op) begin
                bytex         = 1'b1;
                rega_byte_enx = c_BE_LOW;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_group_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_group_decoder
// Brief    : Directed scoreboard bench for load_store_group_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_group_decoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] opf;
    logic [2:0] modef;
    logic       fetch, decode, execute, commit;
    logic       rega_en, regb_en, rega_wen, regb_wen;
    logic [3:0] alu_opx;
    logic [2:0] alua_srcx, alub_srcx, regb_addrx;
    logic [1:0] rega_dinx, rega_addrx, rega_byte_enx, regb_byte_enx;
    logic [1:0] data_busx, addr_busx, pc_offsetx;
    logic       rdx, wrx, bytex;

    int n_assert = 0;
    int n_fail   = 0;

    logic [33:0] sb_q[$];
    string       tag_q[$];
    logic [1:0]  m_opf;
    logic [2:0]  m_mode;

    load_store_group_decoder dut (
        .clk(clk), .rst_n(rst_n), .opf(opf), .modef(modef),
        .fetch(fetch), .decode(decode), .execute(execute), .commit(commit),
        .rega_en(rega_en), .regb_en(regb_en), .rega_wen(rega_wen), .regb_wen(regb_wen),
        .alu_opx(alu_opx), .alua_srcx(alua_srcx), .alub_srcx(alub_srcx),
        .rega_dinx(rega_dinx), .rega_addrx(rega_addrx), .regb_addrx(regb_addrx),
        .rega_byte_enx(rega_byte_enx), .regb_byte_enx(regb_byte_enx),
        .data_busx(data_busx), .addr_busx(addr_busx),
        .rdx(rdx), .wrx(wrx), .bytex(bytex), .pc_offsetx(pc_offsetx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector from the instruction-set tables.
    function automatic logic [33:0] model(input logic [1:0] op, input logic [2:0] md,
                                          input logic ex, input logic cm, input logic rs);
        logic       en, ra_w, rb_w, rd, wr, by, is_ld, bop;
        logic [2:0] alua, rb_addr;
        logic [1:0] ra_be, db, ab, pco;
        en = 0; ra_w = 0; rb_w = 0; rd = 0; wr = 0; by = 0;
        alua = 3'd0; rb_addr = 3'd0; ra_be = 2'b11; db = 2'd0; ab = 2'd0; pco = 2'd0;
        if (rs && (ex || cm) && md != 3'd7) begin
            is_ld = (op == 2'b00) || (op == 2'b10);
`ifdef LDS_BYTE_OPS_EN
            bop = (op == 2'b10) || (op == 2'b11);
`else
            bop = 1'b0;
`endif
            en = 1;
            case (md)
                3'd0: begin alua = 3'd0; ab = 2'd1; end
                3'd1: begin alua = 3'd2; ab = 2'd1; rb_w = cm; end
                3'd2: begin alua = 3'd3; ab = 2'd2; rb_w = cm; end
                3'd3: begin alua = 3'd0; ab = 2'd3; if (cm) pco = 2'd1; end
                3'd4: begin alua = 3'd1; ab = 2'd2; rb_addr = 3'd1; end
                3'd5: begin alua = 3'd1; ab = 2'd2; rb_addr = 3'd2; end
                default: begin alua = 3'd1; ab = 2'd2; rb_addr = 3'd3; end
            endcase
            if (is_ld) begin rd = 1; ra_w = cm; end
            else       begin db = 2'd1; wr = cm; end
            if (bop)   begin by = 1; ra_be = 2'b01; end
        end
        return {en, en, ra_w, rb_w, 4'd0, alua, 3'd0, 2'd0, 2'd0, rb_addr,
                ra_be, 2'b11, db, ab, rd, wr, by, pco};
    endfunction

    function automatic logic [33:0] observed();
        return {rega_en, regb_en, rega_wen, regb_wen, alu_opx, alua_srcx, alub_srcx,
                rega_dinx, rega_addrx, regb_addrx, rega_byte_enx, regb_byte_enx,
                data_busx, addr_busx, rdx, wrx, bytex, pc_offsetx};
    endfunction

    task automatic push_expect(input string tag);
        sb_q.push_back(model(m_opf, m_mode, execute, commit, rst_n));
        tag_q.push_back(tag);
    endtask

    task automatic check();
        logic [33:0] exp_v;
        string       tag;
        logic [33:0] obs;
        exp_v = sb_q.pop_front();
        tag   = tag_q.pop_front();
        obs   = observed();
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic phase(input string tag, input logic f, input logic d, input logic e,
                         input logic c, input logic [1:0] op, input logic [2:0] md);
        @(negedge clk);
        fetch = f; decode = d; execute = e; commit = c;
        opf = op; modef = md;
        push_expect(tag);
        #2 check();
        if (d) begin
            @(posedge clk);
            m_opf  = op;
            m_mode = md;
        end
    endtask

    // Non-decode phases drive random opcode/mode to prove they are not latched.
    task automatic instr(input string tag, input logic [1:0] op, input logic [2:0] md);
        phase({tag, "_fetch"},  1, 0, 0, 0, 2'($urandom_range(3)), 3'($urandom_range(7)));
        phase({tag, "_decode"}, 0, 1, 0, 0, op, md);
        phase({tag, "_exec"},   0, 0, 1, 0, 2'($urandom_range(3)), 3'($urandom_range(7)));
        phase({tag, "_commit"}, 0, 0, 0, 1, 2'($urandom_range(3)), 3'($urandom_range(7)));
    endtask

    initial begin
        rst_n = 0; opf = 2'b00; modef = 3'd0;
        fetch = 0; decode = 0; execute = 1; commit = 0;
        m_opf = 2'b00; m_mode = 3'd0;
        #3;
        push_expect("reset_exec");
        check();
        commit = 1; execute = 0;
        #1 push_expect("reset_commit");
        check();
        @(negedge clk);
        commit = 0;
        rst_n = 1;

        instr("ld_m0",  2'b00, 3'd0);
        instr("ld_m2",  2'b00, 3'd2);
        instr("ld_m1",  2'b00, 3'd1);
        instr("st_m0",  2'b01, 3'd0);
        instr("ld_m4",  2'b00, 3'd4);
        instr("ld_m5",  2'b00, 3'd5);
        instr("ld_m6",  2'b00, 3'd6);
        instr("ld_m3",  2'b00, 3'd3);
        instr("ldb_m0", 2'b10, 3'd0);
        instr("stb_m1", 2'b11, 3'd1);
        instr("st_m3",  2'b01, 3'd3);
        instr("ld_m7",  2'b00, 3'd7);

        // Abort an LD (--Rb) in COMMIT with reset.
        phase("abort_fetch",  1, 0, 0, 0, 2'b00, 3'd0);
        phase("abort_decode", 0, 1, 0, 0, 2'b00, 3'd2);
        phase("abort_exec",   0, 0, 1, 0, 2'b01, 3'd5);
        phase("abort_commit", 0, 0, 0, 1, 2'b01, 3'd5);
        #1 rst_n = 0;
        m_opf = 2'b00; m_mode = 3'd0;
        #1 push_expect("abort_reset_now");
        check();
        @(negedge clk);
        push_expect("abort_reset_hold");
        #1 check();
        rst_n = 1;
        // No decode after reset: cleared fields behave as LD mode 0.
        phase("post_reset_exec",   0, 0, 1, 0, 2'b11, 3'd6);
        phase("post_reset_commit", 0, 0, 0, 1, 2'b11, 3'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
